// File: rtl/wb_port_arbiter.sv
// Shares the RF write port: WB pipe wins, MDU results queue in a FIFO; rf_* registered (1 cycle).
// Backpressure: mdu_ready drops when the FIFO is full; pipe_stall forces bubbles until it drains.
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 2,
  parameter int MAX_DEFER = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_waddr,
  input  logic [DATA_W-1:0] mdu_wdata,
  output logic              mdu_ready,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DEF_W = $clog2(MAX_DEFER + 1);

  typedef enum logic {NORMAL, STALL} state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] entAddr [DEPTH];
  logic [DATA_W-1:0] entData [DEPTH];
  logic [DEPTH-1:0]  entLive;
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  count, nextCount;
  logic [DEF_W-1:0]  deferCnt, nextDefer;
  logic              inStall, pipeReq, fifoEmpty, push, pop, headLive, drainWrite;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // r0 is hard-wired: such writes count as no request and are never queued.
  assign inStall    = (state == STALL);
  assign pipeReq    = pipe_we && (pipe_waddr != '0) && !inStall;
  assign fifoEmpty  = (count == '0);
  assign mdu_ready  = (count < CNT_W'(DEPTH));
  assign push       = mdu_valid && mdu_ready && (mdu_waddr != '0);
  assign pop        = !fifoEmpty && (inStall || !pipeReq);
  assign headLive   = entLive[rdPtr];
  assign drainWrite = pop && headLive;
  assign nextCount  = count + CNT_W'(push) - CNT_W'(pop);
  assign nextDefer  = (inStall || fifoEmpty || pop) ? '0 : deferCnt + DEF_W'(1);

  always_comb begin
    nextState = state;
    if (state == NORMAL) begin
      if (nextCount == CNT_W'(DEPTH) || nextDefer == DEF_W'(MAX_DEFER))
        nextState = STALL;
    end else if (nextCount == '0) begin
      nextState = NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entAddr[wrPtr] <= mdu_waddr;
      entData[wrPtr] <= mdu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= NORMAL;
      pipe_stall <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      deferCnt   <= '0;
      entLive    <= '0;
    end else begin
      rf_we <= pipeReq || drainWrite;
      if (pipeReq) begin
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end else if (drainWrite) begin
        rf_waddr <= entAddr[rdPtr];
        rf_wdata <= entData[rdPtr];
      end else begin
        rf_waddr <= '0;
        rf_wdata <= '0;
      end

      // A granted pipe write is younger than anything queued for the same register.
      if (pipeReq) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entAddr[i] == pipe_waddr) entLive[i] <= 1'b0;
        end
      end
      if (push) begin
        entLive[wrPtr] <= !(pipeReq && (mdu_waddr == pipe_waddr));
        wrPtr          <= ptrInc(wrPtr);
      end
      if (pop) rdPtr <= ptrInc(rdPtr);

      count      <= nextCount;
      deferCnt   <= nextDefer;
      state      <= nextState;
      pipe_stall <= (nextState == STALL);
    end
  end

  pipeQuietInStall: assert property (@(posedge clk) disable iff (reset) inStall |-> !pipe_we);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected RF writes queued at stimulus time, popped by a monitor.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_waddr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_waddr = '0;
  logic [31:0] mdu_wdata = '0;
  logic        mdu_ready, pipe_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wrEntry_t;

  wrEntry_t expQ[$];
  int       nRun = 0;
  int       nFail = 0;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .MAX_DEFER(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nRun++;
    if (got !== want) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Monitor: every RF write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wrEntry_t e;
    if (!reset && rf_we === 1'b1) begin
      if (expQ.size() == 0) begin
        nRun++;
        nFail++;
        $display("FAIL rf_unexpected: got write r%0d=0x%0h, want no write", rf_waddr, rf_wdata);
      end else begin
        e = expQ.pop_front();
        check("rf_waddr", 32'(rf_waddr), 32'(e.addr));
        check("rf_wdata", rf_wdata, e.data);
      end
    end
  end

  task automatic expWr(input logic [4:0] a, input logic [31:0] d);
    wrEntry_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic cyc(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md);
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    mdu_valid = 1'b0; mdu_waddr = 5'd0; mdu_wdata = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drained(input string name);
    idle(6);
    check(name, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    #1;
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_pipe_stall", 32'(pipe_stall), 32'd0);
    check("reset_mdu_ready", 32'(mdu_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle drain of a single MDU result.
    expWr(5'd5, 32'hDEAD0005);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD0005);
    drained("idle_drain");

    // Starvation: four deferred cycles, then one forced bubble.
    for (int k = 0; k < 5; k++) begin
      expWr(5'd3, 32'h33000000 + 32'(k));
      cyc(1'b1, 5'd3, 32'h33000000 + 32'(k), (k == 0), 5'd7, 32'h77770007);
      check("starve_stall", 32'(pipe_stall), (k == 4) ? 32'd1 : 32'd0);
    end
    expWr(5'd7, 32'h77770007);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("starve_release", 32'(pipe_stall), 32'd0);
    expWr(5'd3, 32'h33000006);
    cyc(1'b1, 5'd3, 32'h33000006, 1'b0, 5'd0, 32'd0);
    drained("starve_drain");

    // Full FIFO forces STALL; entries drain in order.
    expWr(5'd3, 32'h44000000);
    cyc(1'b1, 5'd3, 32'h44000000, 1'b1, 5'd10, 32'hA0A0000A);
    check("full_ready_1", 32'(mdu_ready), 32'd1);
    check("full_stall_1", 32'(pipe_stall), 32'd0);
    expWr(5'd3, 32'h44000001);
    cyc(1'b1, 5'd3, 32'h44000001, 1'b1, 5'd11, 32'hB0B0000B);
    check("full_ready_2", 32'(mdu_ready), 32'd0);
    check("full_stall_2", 32'(pipe_stall), 32'd1);
    expWr(5'd10, 32'hA0A0000A);
    idle(1);
    check("full_stall_3", 32'(pipe_stall), 32'd1);
    check("full_ready_3", 32'(mdu_ready), 32'd1);
    expWr(5'd11, 32'hB0B0000B);
    idle(1);
    check("full_stall_4", 32'(pipe_stall), 32'd0);
    drained("full_drain");

    // WAW: queued r9 result is superseded by a younger pipe write.
    expWr(5'd4, 32'h55000004);
    cyc(1'b1, 5'd4, 32'h55000004, 1'b1, 5'd9, 32'h00000001);
    expWr(5'd9, 32'h00000002);
    cyc(1'b1, 5'd9, 32'h00000002, 1'b0, 5'd0, 32'd0);
    check("waw_pipe_we", 32'(rf_we), 32'd1);
    idle(1);
    check("waw_skip_we", 32'(rf_we), 32'd0);
    check("waw_ready", 32'(mdu_ready), 32'd1);
    drained("waw_drain");

    // WAW with a same-cycle push to the same register.
    expWr(5'd9, 32'h00000003);
    cyc(1'b1, 5'd9, 32'h00000003, 1'b1, 5'd9, 32'h00000099);
    drained("waw_same_cycle");

    // r0 writes from either source never reach the RF or the FIFO.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 5'd0, 32'h0BAD0000, 1'b1, 5'd0, 32'h0BAD0001);
      check("r0_rf_we", 32'(rf_we), 32'd0);
      check("r0_ready", 32'(mdu_ready), 32'd1);
    end
    check("r0_stall", 32'(pipe_stall), 32'd0);
    drained("r0_drain");

    // Reset while the FIFO is full and draining.
    expWr(5'd3, 32'h11000000);
    cyc(1'b1, 5'd3, 32'h11000000, 1'b1, 5'd12, 32'h0000000C);
    expWr(5'd3, 32'h11000001);
    cyc(1'b1, 5'd3, 32'h11000001, 1'b1, 5'd13, 32'h0000000D);
    quiet();
    check("pre_reset_stall", 32'(pipe_stall), 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset_rf_we", 32'(rf_we), 32'd0);
    check("midreset_stall", 32'(pipe_stall), 32'd0);
    check("midreset_ready", 32'(mdu_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    expWr(5'd14, 32'h0000000E);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h0000000E);
    drained("post_reset_drain");

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end
endmodule
